// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Round-robin arbiter sharing one downstream resource between NUM_REQ
//   requesters. Issues a registered one-hot grant plus its binary index,
//   holds the grant until the owner releases it (done, request drop, or
//   starvation limit), and re-arbitrates in the same cycle so back-to-back
//   owners see no idle gap.
//
// Parameters
//   NUM_REQ  : number of requesters (>= 2, any value)
//   MAX_HOLD : max consecutive grant cycles while another requester waits;
//              0 disables the limit
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   arbitration enable; 0 blocks new grants only
//   req      in   [NUM_REQ]  level-sensitive requests
//   done     in   current owner releases the grant
//   gnt      out  [NUM_REQ]  registered one-hot grant
//   gnt_idx  out  [IDX_W]    registered binary index of gnt (0 when idle)
//   gnt_vld  out  a grant is active (|gnt)
//   busy     out  arbiter is in the GRANT state
module rr_arbiter #(
    parameter int  NUM_REQ  = 4,
    parameter int  MAX_HOLD = 8,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_vld,
    output logic               busy
);

    localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HC_W'(MAX_HOLD - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [HC_W-1:0]    hold_cnt;

    logic [NUM_REQ-1:0] cand_req;
    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   win_next;
    logic               others;
    logic               limit_hit;
    logic               rel;

    // Release evaluation; on release the owner's bit is masked so a forced
    // release cannot hand the grant straight back to the same requester.
    always_comb begin
        others    = |(req & ~gnt);
        limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && others;
        rel       = (state == GRANT) && (done || !req[gnt_idx] || limit_hit);
        cand_req  = (state == GRANT) ? (req & ~gnt) : req;
    end

    // Search from ptr upward with explicit wrap so non-power-of-2 counts work.
    always_comb begin
        int unsigned pos;
        pos   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && cand_req[IDX_W'(pos)]) begin
                found = 1'b1;
                win   = IDX_W'(pos);
            end
        end
        win_next = (win == LAST_IDX) ? '0 : win + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_idx  <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && found) begin
                        state    <= GRANT;
                        gnt      <= NUM_REQ'(1) << win;
                        gnt_idx  <= win;
                        ptr      <= win_next;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        if (en && found) begin
                            gnt      <= NUM_REQ'(1) << win;
                            gnt_idx  <= win;
                            ptr      <= win_next;
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            gnt      <= '0;
                            gnt_idx  <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HC_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    gnt      <= '0;
                    gnt_idx  <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt_vld = |gnt;
    assign busy    = (state == GRANT);

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed testbench for rr_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Inputs change 1 time unit after each rising edge; outputs are checked
// at the same point, i.e. away from the active edge.
module tb_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       busy;

    int unsigned n_cmp;
    int unsigned n_bad;

    rr_arbiter #(
        .NUM_REQ  (4),
        .MAX_HOLD (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".gnt"},     32'(gnt),     32'h0);
        check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'h0);
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'h0);
        check({tag, ".busy"},    32'(busy),    32'h0);
    endtask

    task automatic expect_owner(input string tag, input int idx);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        check({tag, ".gnt"},     32'(gnt),     32'(oh));
        check({tag, ".gnt_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'h1);
        check({tag, ".busy"},    32'(busy),    32'h1);
    endtask

    // Called right after an edge+1; reset released before the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        done  = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int seq [5];
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        req   = '0;
        done  = 1'b0;

        // Reset and idle
        #1;
        expect_idle("reset_async");
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            expect_idle("idle");
        end

        // Rotation with done every 3rd cycle
        seq = '{0, 1, 2, 3, 0};
        en  = 1'b1;
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            expect_owner("rot_a", seq[k]);
            step();
            expect_owner("rot_b", seq[k]);
            step();
            expect_owner("rot_c", seq[k]);
            done = 1'b1;
            step();
            done = 1'b0;
        end
        expect_owner("rot_next", 1);

        // Wrap and skip
        do_reset();
        en  = 1'b1;
        req = 4'b1000;
        step();
        expect_owner("wrap_3", 3);
        req  = 4'b0101;
        done = 1'b1;
        step();
        expect_owner("wrap_0", 0);
        step();
        expect_owner("skip_2", 2);
        req = 4'b0001;
        step();
        expect_owner("only_0", 0);
        done = 1'b0;

        // Simultaneous done and owner request drop: single pointer advance
        do_reset();
        en  = 1'b1;
        req = 4'b1111;
        step();
        expect_owner("sim_0", 0);
        req  = 4'b1110;
        done = 1'b1;
        step();
        expect_owner("sim_1", 1);
        req = 4'b1111;
        step();
        expect_owner("sim_2", 2);
        done = 1'b0;

        // Starvation limit
        do_reset();
        en  = 1'b1;
        req = 4'b0011;
        step();
        for (int c = 0; c < 8; c++) begin
            expect_owner("starve_0", 0);
            step();
        end
        for (int c = 0; c < 8; c++) begin
            expect_owner("starve_1", 1);
            step();
        end
        expect_owner("starve_back0", 0);
        req = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            step();
            expect_owner("solo_hold", 0);
        end

        // Enable gating
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        step();
        expect_owner("en_own2", 2);
        en  = 1'b0;
        req = 4'b1111;
        step();
        expect_owner("en_hold2", 2);
        done = 1'b1;
        req  = 4'b1011;
        step();
        expect_idle("en_off_rel");
        done = 1'b0;
        step();
        expect_idle("en_off_stay");
        en = 1'b1;
        step();
        expect_owner("en_on_3", 3);

        // Async reset mid-grant
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        step();
        expect_owner("ar_own2", 2);
        #2;
        rst_n = 1'b0;
        #1;
        expect_idle("ar_drop");
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        expect_owner("ar_ptr0", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
